// File: rtl/axil_arb2_ctrl.sv
// rtl/axil_arb2_ctrl.sv - two-master round-robin AXI4-Lite arbiter in front of one shared slave port
// Optional response watchdog with late-response drain: AXIL_ARB_TIMEOUT_EN
module axil_arb2_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0]                m_awvalid,
    input  logic [2*ADDR_W-1:0]       m_awaddr,
    output logic [1:0]                m_awready,
    input  logic [1:0]                m_wvalid,
    input  logic [2*DATA_W-1:0]       m_wdata,
    input  logic [2*(DATA_W/8)-1:0]   m_wstrb,
    output logic [1:0]                m_wready,
    output logic [1:0]                m_bvalid,
    output logic [3:0]                m_bresp,
    input  logic [1:0]                m_bready,
    input  logic [1:0]                m_arvalid,
    input  logic [2*ADDR_W-1:0]       m_araddr,
    output logic [1:0]                m_arready,
    output logic [1:0]                m_rvalid,
    output logic [2*DATA_W-1:0]       m_rdata,
    output logic [3:0]                m_rresp,
    input  logic [1:0]                m_rready,
    output logic                      s_awvalid,
    output logic [ADDR_W-1:0]         s_awaddr,
    input  logic                      s_awready,
    output logic                      s_wvalid,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [(DATA_W/8)-1:0]     s_wstrb,
    input  logic                      s_wready,
    input  logic                      s_bvalid,
    input  logic [1:0]                s_bresp,
    output logic                      s_bready,
    output logic                      s_arvalid,
    output logic [ADDR_W-1:0]         s_araddr,
    input  logic                      s_arready,
    input  logic                      s_rvalid,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic [1:0]                s_rresp,
    output logic                      s_rready
);

    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic gw, gw_nxt, last_w, last_w_nxt;
    logic aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic gr, gr_nxt, last_r, last_r_nxt;

    logic w_to, r_to;
    logic w_drain, r_drain;

    // Round-robin: on a tie the master that did not win last time gets the grant.
    function automatic logic pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return ~last;
        return req[1];
    endfunction

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] w_cnt, r_cnt;

    assign w_to = (w_state == W_RESP) && (w_cnt == TO_W'(TIMEOUT_CYC));
    assign r_to = (r_state == R_DATA) && (r_cnt == TO_W'(TIMEOUT_CYC));

    // Counters saturate at the limit; the drain flag swallows the slave's eventual late response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_cnt   <= '0;
            r_cnt   <= '0;
            w_drain <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            if (w_state != W_RESP)  w_cnt <= '0;
            else if (!w_to)         w_cnt <= w_cnt + TO_W'(1);

            if (r_state != R_DATA)  r_cnt <= '0;
            else if (!r_to)         r_cnt <= r_cnt + TO_W'(1);

            if (w_to && m_bready[gw])        w_drain <= 1'b1;
            else if (w_drain && s_bvalid)    w_drain <= 1'b0;

            if (r_to && m_rready[gr])        r_drain <= 1'b1;
            else if (r_drain && s_rvalid)    r_drain <= 1'b0;
        end
    end
`else
    assign w_to    = 1'b0;
    assign r_to    = 1'b0;
    assign w_drain = 1'b0;
    assign r_drain = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state <= W_IDLE;
            gw      <= 1'b0;
            last_w  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            r_state <= R_IDLE;
            gr      <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            w_state <= w_state_nxt;
            gw      <= gw_nxt;
            last_w  <= last_w_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            r_state <= r_state_nxt;
            gr      <= gr_nxt;
            last_r  <= last_r_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        gw_nxt      = gw;
        last_w_nxt  = last_w;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        m_awready   = '0;
        m_wready    = '0;
        m_bvalid    = '0;
        m_bresp     = '0;
        s_awvalid   = 1'b0;
        s_awaddr    = '0;
        s_wvalid    = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_bready    = w_drain;
        unique case (w_state)
            W_IDLE: begin
                if ((|m_awvalid) && !w_drain) begin
                    gw_nxt      = pick(m_awvalid, last_w);
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                // AW and W complete independently; each is masked once its handshake is latched.
                s_awvalid     = m_awvalid[gw] & ~aw_done;
                s_awaddr      = m_awaddr[gw*ADDR_W +: ADDR_W];
                m_awready[gw] = s_awready & ~aw_done;
                s_wvalid      = m_wvalid[gw] & ~w_done;
                s_wdata       = m_wdata[gw*DATA_W +: DATA_W];
                s_wstrb       = m_wstrb[gw*SW +: SW];
                m_wready[gw]  = s_wready & ~w_done;
                aw_done_nxt   = aw_done | (s_awvalid & s_awready);
                w_done_nxt    = w_done | (s_wvalid & s_wready);
                if (aw_done_nxt && w_done_nxt) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (w_to) begin
                    m_bvalid[gw]       = 1'b1;
                    m_bresp[gw*2 +: 2] = 2'b10;
                    if (m_bready[gw]) begin
                        last_w_nxt  = gw;
                        w_state_nxt = W_IDLE;
                    end
                end else begin
                    s_bready           = m_bready[gw];
                    m_bvalid[gw]       = s_bvalid;
                    m_bresp[gw*2 +: 2] = s_bresp;
                    if (s_bvalid && m_bready[gw]) begin
                        last_w_nxt  = gw;
                        w_state_nxt = W_IDLE;
                    end
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        gr_nxt      = gr;
        last_r_nxt  = last_r;
        m_arready   = '0;
        m_rvalid    = '0;
        m_rdata     = {2{s_rdata}};
        m_rresp     = {2{s_rresp}};
        s_arvalid   = 1'b0;
        s_araddr    = '0;
        s_rready    = r_drain;
        unique case (r_state)
            R_IDLE: begin
                if ((|m_arvalid) && !r_drain) begin
                    gr_nxt      = pick(m_arvalid, last_r);
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                s_arvalid     = m_arvalid[gr];
                s_araddr      = m_araddr[gr*ADDR_W +: ADDR_W];
                m_arready[gr] = s_arready;
                if (s_arvalid && s_arready) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                if (r_to) begin
                    m_rvalid[gr] = 1'b1;
                    m_rdata      = '0;
                    m_rresp      = {2{2'b10}};
                    if (m_rready[gr]) begin
                        last_r_nxt  = gr;
                        r_state_nxt = R_IDLE;
                    end
                end else begin
                    s_rready     = m_rready[gr];
                    m_rvalid[gr] = s_rvalid;
                    if (s_rvalid && m_rready[gr]) begin
                        last_r_nxt  = gr;
                        r_state_nxt = R_IDLE;
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_arb2_ctrl.sv
// tb/tb_axil_arb2_ctrl.sv - directed scoreboard bench for axil_arb2_ctrl
module tb_axil_arb2_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  m_awvalid = '0, m_awready, m_wvalid = '0, m_wready;
    logic [1:0]  m_bvalid, m_bready = 2'b11, m_arvalid = '0, m_arready;
    logic [1:0]  m_rvalid, m_rready = 2'b11;
    logic [63:0] m_awaddr = '0, m_wdata = '0, m_araddr = '0, m_rdata;
    logic [7:0]  m_wstrb = '0;
    logic [3:0]  m_bresp, m_rresp;
    logic        s_awvalid, s_awready = 1'b1, s_wvalid, s_wready = 1'b1;
    logic        s_bvalid, s_bready, s_arvalid, s_arready = 1'b1, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;

    always #5 clk_i = ~clk_i;

    axil_arb2_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t b_q[$];
    exp_t r_q[$];

    // Slave model: memory with one-cycle B/R turnaround; hold_r withholds read data.
    logic        hold_r = 1'b0;
    logic        got_aw, got_w, r_pend;
    logic [31:0] aw_q, wd_q, ar_q;
    logic [31:0] mem [0:255];

    initial for (int k = 0; k < 256; k++) mem[k] = 32'hC0DE_0000 | k;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_bvalid <= 1'b0; s_bresp <= 2'b00; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= 2'b00;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
        end else begin
            if (s_awvalid && s_awready) begin aw_q <= s_awaddr; got_aw <= 1'b1; end
            if (s_wvalid && s_wready) begin wd_q <= s_wdata; got_w <= 1'b1; end
            if (got_aw && got_w) begin
                mem[aw_q[9:2]] <= wd_q;
                got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b1; s_bresp <= 2'b00;
            end else if (s_bvalid && s_bready) s_bvalid <= 1'b0;
            if (s_arvalid && s_arready) begin ar_q <= s_araddr; r_pend <= 1'b1; end
            if (r_pend && !hold_r) begin
                s_rvalid <= 1'b1; s_rdata <= mem[ar_q[9:2]]; s_rresp <= 2'b00; r_pend <= 1'b0;
            end else if (s_rvalid && s_rready) s_rvalid <= 1'b0;
        end
    end

    // Response monitor: every master-side B/R beat pops and checks the scoreboard.
    exp_t eb, er;
    always @(negedge clk_i) begin
        if (rst_ni && (|m_bvalid)) begin
            vectors++;
            assert (b_q.size() > 0) else begin errors++; $error("FAIL b_unexpected m_bvalid=%b expected none", m_bvalid); end
            if (b_q.size() > 0) begin
                eb = b_q.pop_front();
                vectors++;
                assert (m_bvalid === 2'(1 << eb.id)) else begin errors++; $error("FAIL b_master m_bvalid=%b expected %b", m_bvalid, 2'(1 << eb.id)); end
                vectors++;
                assert (m_bresp[eb.id*2 +: 2] === eb.resp) else begin errors++; $error("FAIL b_resp got=%b expected %b", m_bresp[eb.id*2 +: 2], eb.resp); end
            end
        end
        if (rst_ni && (|m_rvalid)) begin
            vectors++;
            assert (r_q.size() > 0) else begin errors++; $error("FAIL r_unexpected m_rvalid=%b rdata=%h expected none", m_rvalid, m_rdata[31:0]); end
            if (r_q.size() > 0) begin
                er = r_q.pop_front();
                vectors++;
                assert (m_rvalid === 2'(1 << er.id)) else begin errors++; $error("FAIL r_master m_rvalid=%b expected %b", m_rvalid, 2'(1 << er.id)); end
                vectors++;
                assert (m_rdata[er.id*32 +: 32] === er.data) else begin errors++; $error("FAIL r_data got=%h expected %h", m_rdata[er.id*32 +: 32], er.data); end
                vectors++;
                assert (m_rresp[er.id*2 +: 2] === er.resp) else begin errors++; $error("FAIL r_resp got=%b expected %b", m_rresp[er.id*2 +: 2], er.resp); end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin errors++; $error("FAIL %s got=%h expected %h", tag, got, exp); end
    endtask

    task automatic check_idle_outs(input string tag);
        check(tag, {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                    s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 64'h0);
        check({tag, "_payload"}, {s_awaddr, s_araddr} | {32'h0, s_wdata}, 64'h0);
    endtask

    task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d, input int aw_lag);
        bit aw_p = 1'b1, w_p = 1'b1, aw_hs, w_hs;
        int n = 0;
        @(posedge clk_i); #1;
        m_wvalid[i] = 1'b1; m_wdata[i*32 +: 32] = d; m_wstrb[i*4 +: 4] = 4'hF;
        if (aw_lag == 0) begin m_awvalid[i] = 1'b1; m_awaddr[i*32 +: 32] = a; end
        while ((aw_p || w_p) && n < 100) begin
            @(negedge clk_i);
            aw_hs = m_awvalid[i] && m_awready[i];
            w_hs  = m_wvalid[i] && m_wready[i];
            @(posedge clk_i); #1;
            n++;
            if (aw_hs) begin m_awvalid[i] = 1'b0; aw_p = 1'b0; end
            if (w_hs)  begin m_wvalid[i] = 1'b0; w_p = 1'b0; end
            if (aw_p && !m_awvalid[i] && n >= aw_lag) begin m_awvalid[i] = 1'b1; m_awaddr[i*32 +: 32] = a; end
        end
        vectors++;
        assert (n < 100) else begin errors++; $error("FAIL wr_timeout m%0d cycles=%0d expected <100", i, n); end
        m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [31:0] a);
        bit hs = 1'b0;
        int n = 0;
        @(posedge clk_i); #1;
        m_arvalid[i] = 1'b1; m_araddr[i*32 +: 32] = a;
        while (!hs && n < 100) begin
            @(negedge clk_i);
            hs = m_arvalid[i] && m_arready[i];
            @(posedge clk_i); #1;
            n++;
        end
        m_arvalid[i] = 1'b0;
        vectors++;
        assert (hs) else begin errors++; $error("FAIL rd_timeout m%0d cycles=%0d expected handshake", i, n); end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((b_q.size() > 0 || r_q.size() > 0) && n < 200) begin @(negedge clk_i); n++; end
        vectors++;
        assert (b_q.size() == 0 && r_q.size() == 0)
        else begin errors++; $error("FAIL %s pending b=%0d r=%0d expected 0", tag, b_q.size(), r_q.size()); end
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit hs;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_idle_outs("reset_outs");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // 1: single m0 read, one-cycle grant latency
        @(posedge clk_i); #1;
        r_q.push_back('{0, 32'hDEAD_BEEF, 2'b00});
        mem[8'h40] = 32'hDEAD_BEEF;
        m_arvalid[0] = 1'b1; m_araddr[31:0] = 32'h100;
        @(negedge clk_i);
        check("t1_no_grant_yet", {63'h0, s_arvalid}, 64'h0);
        @(negedge clk_i);
        check("t1_s_arvalid", {63'h0, s_arvalid}, 64'h1);
        check("t1_s_araddr", {32'h0, s_araddr}, 64'h100);
        check("t1_m_arready", {62'h0, m_arready}, 64'h1);
        @(posedge clk_i); #1;
        m_arvalid[0] = 1'b0;
        wait_drain("t1");

        // 2: simultaneous writes, grants alternate 0,1,0,1
        b_q.push_back('{0, 32'h0, 2'b00});
        b_q.push_back('{1, 32'h0, 2'b00});
        b_q.push_back('{0, 32'h0, 2'b00});
        b_q.push_back('{1, 32'h0, 2'b00});
        fork
            begin do_write(0, 32'h10, 32'h1111_0000, 0); do_write(0, 32'h14, 32'h1111_0001, 0); end
            begin do_write(1, 32'h20, 32'h2222_0000, 0); do_write(1, 32'h24, 32'h2222_0001, 0); end
        join
        wait_drain("t2");
        r_q.push_back('{1, 32'h2222_0001, 2'b00});
        do_read(1, 32'h24);
        wait_drain("t2_readback");

        // 3: W leads AW by 3 cycles, slave AW stalled; B only after AW completes
        s_awready = 1'b0;
        b_q.push_back('{1, 32'h0, 2'b00});
        fork
            do_write(1, 32'h30, 32'h3333_3333, 3);
            begin
                repeat (8) @(posedge clk_i);
                @(negedge clk_i);
                check("t3_w_done_masks_wvalid", {63'h0, s_wvalid}, 64'h0);
                check("t3_aw_still_pending", {63'h0, s_awvalid}, 64'h1);
                check("t3_no_early_b", {62'h0, m_bvalid}, 64'h0);
                @(posedge clk_i); #1;
                s_awready = 1'b1;
            end
        join
        wait_drain("t3");

        // 4: concurrent m0 read and m1 write
        r_q.push_back('{0, 32'hC0DE_0080, 2'b00});
        b_q.push_back('{1, 32'h0, 2'b00});
        fork
            do_read(0, 32'h200);
            do_write(1, 32'h300, 32'h4444_4444, 0);
        join
        wait_drain("t4");

        // 5: reset in W_ADDR after AW handshake, W outstanding
        s_wready = 1'b0;
        @(posedge clk_i); #1;
        m_awvalid[1] = 1'b1; m_awaddr[63:32] = 32'h50;
        m_wvalid[1] = 1'b1; m_wdata[63:32] = 32'h5555_5555; m_wstrb[7:4] = 4'hF;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk_i);
            hs = m_awready[1];
            @(posedge clk_i); #1;
        end
        m_awvalid[1] = 1'b0;
        check("t5_aw_handshake", {63'h0, hs}, 64'h1);
        @(negedge clk_i);
        check("t5_aw_done_latched", {62'h0, s_awvalid, s_wvalid}, 64'h1);
        rst_ni = 1'b0;
        #1;
        check_idle_outs("t5_reset_outs");
        m_wvalid[1] = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        s_wready = 1'b1;
        b_q.push_back('{0, 32'h0, 2'b00});
        do_write(0, 32'h60, 32'h6666_6666, 0);
        wait_drain("t5");

`ifdef AXIL_ARB_TIMEOUT_EN
        // 6: read watchdog returns SLVERR, late data drained, m1 waits for drain
        hold_r = 1'b1;
        r_q.push_back('{0, 32'h0, 2'b10});
        do_read(0, 32'h40);
        wait_drain("t6_timeout");
        r_q.push_back('{1, 32'hC0DE_0011, 2'b00});
        fork
            do_read(1, 32'h44);
            begin
                repeat (4) begin
                    @(negedge clk_i);
                    check("t6_blocked_by_drain", {63'h0, s_arvalid}, 64'h0);
                end
                @(posedge clk_i); #1;
                hold_r = 1'b0;
            end
        join
        wait_drain("t6");
`endif

        repeat (3) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
